// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM encoding and default sizing for the weighted round-robin arbiter
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int REQS_DEF = 4;
    localparam int WW_DEF   = 3;

endpackage

// File: rtl/wrr_arbiter_if.sv
// rtl/wrr_arbiter_if.sv - request/grant bundle for wrr_arbiter; optional lock input under WRR_LOCK_EN
interface wrr_arbiter_if
    import arb_pkg::*;
#(
    parameter int REQS = REQS_DEF,
    parameter int WW   = WW_DEF
);

    logic [REQS-1:0]    req;
    logic [REQS*WW-1:0] weight;
    logic               done;
    logic [REQS-1:0]    grant;
    logic               busy;
`ifdef WRR_LOCK_EN
    logic               lock;

    modport master (
        output req,
        output weight,
        output done,
        output lock,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  weight,
        input  done,
        input  lock,
        output grant,
        output busy
    );
`else
    modport master (
        output req,
        output weight,
        output done,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  weight,
        input  done,
        output grant,
        output busy
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search: first active request at or after ptr, wrapping
module rr_pick
    import arb_pkg::*;
#(
    parameter int REQS = REQS_DEF,
    parameter int PW   = $clog2(REQS)
) (
    input  logic [REQS-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [REQS-1:0] winner,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < REQS; k++) begin
            idx = PW'((int'(ptr) + k) % REQS);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter; each grantee holds the grant for weight transfers
// WRR_LOCK_EN adds a lock input that keeps the current grantee past credit exhaustion.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int REQS = REQS_DEF,
    parameter int WW   = WW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    wrr_arbiter_if.slave bus
);

    localparam int PW = $clog2(REQS);

    arb_state_t      state_q, state_d;
    logic [REQS-1:0] grant_q, grant_d;
    logic            busy_q;
    logic [WW-1:0]   credit_q, credit_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;

    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   search_ptr;
    logic [REQS-1:0] winner;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [WW-1:0]   win_weight;
    logic [WW-1:0]   load_credit;
    logic            lock_hold;
    logic            release_now;

`ifdef WRR_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign next_ptr = (gidx_q == PW'(REQS - 1)) ? '0 : gidx_q + 1'b1;

    // Grantee dropping its request releases even while locked.
    assign release_now = (state_q == GRANT) &&
                         (!bus.req[gidx_q] ||
                          (bus.done && (credit_q == WW'(1)) && !lock_hold));

    // Searching from the post-release pointer in the same cycle gives bubble-free hand-off.
    assign search_ptr = release_now ? next_ptr : ptr_q;

    rr_pick #(
        .REQS (REQS),
        .PW   (PW)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (search_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx    = '0;
        win_weight = '0;
        for (int i = 0; i < REQS; i++) begin
            if (winner[i]) begin
                win_idx    = PW'(i);
                win_weight = bus.weight[i*WW +: WW];
            end
        end
    end

    // A zero weight still earns one transfer so the requester is never starved.
    assign load_credit = (win_weight == '0) ? WW'(1) : win_weight;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = GRANT;
                    grant_d  = winner;
                    gidx_d   = win_idx;
                    credit_d = load_credit;
                end else begin
                    grant_d  = '0;
                    credit_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (win_valid) begin
                        grant_d  = winner;
                        gidx_d   = win_idx;
                        credit_d = load_credit;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        credit_d = '0;
                    end
                end else if (bus.done && (credit_q > WW'(1))) begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            credit_q <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            busy_q   <= |grant_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

endmodule
